// File: rtl/pool_layer2_pkg.sv
// pool_layer2_pkg: shared feature type, channel count, FSM states and max helper.
package pool_layer2_pkg;
    typedef logic signed [15:0] feature_t;
    localparam int NCH = 3;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    function automatic feature_t fmax(input feature_t a, input feature_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pool_layer2_pe2.sv
// pool_pe2: one channel of 2x2/stride-2 max pooling (hreg, line buffer, max, ReLU).
module pool_pe2 import pool_layer2_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int IW    = 2,
    parameter int RELU  = 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          i_accept,
    input  logic          i_col_odd,
    input  logic          i_row_odd,
    input  logic [IW-1:0] i_idx,
    input  logic [15:0]   i_pix,
    output logic [15:0]   o_result
);
    feature_t r_hreg, r_out, w_pix, w_hmax, w_max;
    feature_t r_line [DEPTH];
    assign w_pix    = $signed(i_pix);
    assign w_hmax   = fmax(r_hreg, w_pix);
    assign w_max    = fmax(r_line[i_idx], w_hmax);
    assign o_result = r_out;
    // Line buffer needs no reset: each entry is rewritten on an even row before use.
    always_ff @(posedge clk)
        if (i_accept && i_col_odd && !i_row_odd) r_line[i_idx] <= w_hmax;
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            r_hreg <= '0;
            r_out  <= '0;
        end else if (i_accept) begin
            if (!i_col_odd) r_hreg <= w_pix;
            else if (i_row_odd) r_out <= (RELU != 0 && w_max < 0) ? '0 : w_max;
        end
endmodule

// File: rtl/pool_layer2.sv
// pool_layer2: 3-channel 2x2 max-pool layer; shared raster counters and FSM, one pool_pe2 per channel.
module pool_layer2 import pool_layer2_pkg::*; #(
    parameter int IN_W = 8,
    parameter int IN_H = 8,
    parameter int RELU = 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic [NCH:1][15:0] in_feature,
    input  logic               in_valid,
    output logic               ready_pool,
    output logic [NCH:1][15:0] out_feature,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done
);
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int IW = (IN_W > 2) ? $clog2(IN_W / 2) : 1;
    state_t r_state, w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic r_out_valid, r_done, w_done;
    logic w_accept, w_last_col, w_last_row, w_load, w_out_fire;
    logic [IW-1:0] w_idx;
    assign ready_pool = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && ready_pool;
    assign w_last_col = r_col == CW'(IN_W - 1);
    assign w_last_row = r_row == RW'(IN_H - 1);
    assign w_load     = w_accept && r_col[0] && r_row[0];
    assign w_out_fire = r_out_valid && out_ready;
    assign w_idx      = IW'(r_col >> 1);
    assign out_valid  = r_out_valid;
    assign done       = r_done;
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_col && w_last_row) w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire) begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= w_done;
            r_out_valid <= w_load || (r_out_valid && !out_ready);
            if (r_state == S_IDLE && start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                r_col <= w_last_col ? '0 : r_col + CW'(1);
                if (w_last_col) r_row <= w_last_row ? '0 : r_row + RW'(1);
            end
        end
    for (genvar c = 1; c <= NCH; c++) begin : g_pe
        pool_pe2 #(.DEPTH(IN_W / 2), .IW(IW), .RELU(RELU)) u_pe (
            .clk       (clk),
            .n_reset   (n_reset),
            .i_accept  (w_accept),
            .i_col_odd (r_col[0]),
            .i_row_odd (r_row[0]),
            .i_idx     (w_idx),
            .i_pix     (in_feature[c]),
            .o_result  (out_feature[c])
        );
    end
endmodule
